// File: rtl/data_trans_pkg.sv
// Shared types and constants for the data_trans byte-stream framer.
package data_trans_pkg;

    localparam int DATA_W          = 8;
    localparam int CNT_W           = 8;
    localparam int MAX_PAYLOAD_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_CHECK   = 2'd2
    } state_t;

    // Running checksum is a plain XOR accumulate.
    function automatic logic [DATA_W-1:0] csum_step(
        input logic [DATA_W-1:0] acc,
        input logic [DATA_W-1:0] din
    );
        return acc ^ din;
    endfunction

endpackage

// File: rtl/data_trans_core.sv
// Byte-stream framer: forwards header/payload/trailer with one-cycle latency
// and appends an XOR checksum; incomplete or oversized frames are dropped.
module data_trans_core
    import data_trans_pkg::*;
#(
    parameter int MAX_PAYLOAD = MAX_PAYLOAD_DEF
) (
    input  logic              reset_n,
    input  logic              start,
    input  logic              clk,
    input  logic              byte_flag,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_o,
    output logic              data_en
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_PAYLOAD);

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   csum_q, csum_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                emit;
    logic [DATA_W-1:0]   emit_data;
    logic [DATA_W-1:0]   data_p0;
    logic                vld_p0;

    always_comb begin
        state_d   = state_q;
        csum_d    = csum_q;
        cnt_d     = cnt_q;
        emit      = 1'b0;
        emit_data = '0;
        case (state_q)
            ST_IDLE: begin
                if (start && byte_flag) begin
                    emit      = 1'b1;
                    emit_data = data_in;
                    csum_d    = data_in;
                    cnt_d     = '0;
                    state_d   = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                if (!start) begin
                    state_d = ST_IDLE;
                end else if (byte_flag) begin
                    emit      = 1'b1;
                    emit_data = data_in;
                    csum_d    = csum_step(csum_q, data_in);
                    state_d   = ST_CHECK;
                end else if (cnt_q < MAX_CNT) begin
                    emit      = 1'b1;
                    emit_data = data_in;
                    csum_d    = csum_step(csum_q, data_in);
                    cnt_d     = cnt_q + 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CHECK: begin
                // Inputs are ignored here, so the source needs a gap cycle between frames.
                emit      = 1'b1;
                emit_data = csum_q;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Stage p0: state, datapath and registered outputs
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            csum_q  <= '0;
            cnt_q   <= '0;
            data_p0 <= '0;
            vld_p0  <= 1'b0;
        end else begin
            state_q <= state_d;
            csum_q  <= csum_d;
            cnt_q   <= cnt_d;
            data_p0 <= emit ? emit_data : '0;
            vld_p0  <= emit;
        end
    end

    assign data_o  = data_p0;
    assign data_en = vld_p0;

endmodule

// File: tb/tb_data_trans_core.sv
// Directed self-checking bench for data_trans_core (default and MAX_PAYLOAD=2 instances).
module tb_data_trans_core;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start;
    logic       byte_flag;
    logic [7:0] data_in;
    logic [7:0] data_o, data_o2;
    logic       data_en, data_en2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    data_trans_core dut (
        .reset_n(reset_n), .start(start), .clk(clk), .byte_flag(byte_flag),
        .data_in(data_in), .data_o(data_o), .data_en(data_en)
    );

    data_trans_core #(.MAX_PAYLOAD(2)) dut2 (
        .reset_n(reset_n), .start(start), .clk(clk), .byte_flag(byte_flag),
        .data_in(data_in), .data_o(data_o2), .data_en(data_en2)
    );

    task automatic drive(input logic s, input logic b, input logic [7:0] d);
        start     = s;
        byte_flag = b;
        data_in   = d;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        drive(1'b0, 1'b0, 8'h00);
        drive(1'b0, 1'b0, 8'h00);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        if (data_en !== 1'b0) begin errors++; $display("FAIL reset_en: got %b want 0", data_en); end
        checks++;
        if (data_o !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", data_o); end
        checks++;
    endtask

    task automatic test_nominal();
        logic       s_v[7] = '{1, 1, 1, 1, 1, 0, 0};
        logic       b_v[7] = '{1, 0, 0, 0, 1, 0, 0};
        logic [7:0] d_v[7] = '{8'h35, 8'hAF, 8'hE6, 8'hE6, 8'h55, 8'h00, 8'h00};
        logic       e_v[7] = '{1, 1, 1, 1, 1, 1, 0};
        logic [7:0] o_v[7] = '{8'h35, 8'hAF, 8'hE6, 8'hE6, 8'h55, 8'hCF, 8'h00};
        do_reset();
        for (int i = 0; i < 7; i++) begin
            drive(s_v[i], b_v[i], d_v[i]);
            if (data_en !== e_v[i] || data_o !== o_v[i]) begin
                errors++;
                $display("FAIL nominal[%0d]: got en=%b data=%h want en=%b data=%h",
                         i, data_en, data_o, e_v[i], o_v[i]);
            end
            checks++;
        end
    endtask

    task automatic test_reset_mid_frame();
        do_reset();
        drive(1'b1, 1'b1, 8'h35);
        drive(1'b1, 1'b0, 8'hAF);
        reset_n = 1'b0;
        drive(1'b1, 1'b0, 8'hE6);
        reset_n = 1'b1;
        if (data_en !== 1'b0 || data_o !== 8'h00) begin
            errors++;
            $display("FAIL midreset_out: got en=%b data=%h want en=0 data=00", data_en, data_o);
        end
        checks++;
        drive(1'b1, 1'b0, 8'hE6);
        if (data_en !== 1'b0 || data_o !== 8'h00) begin
            errors++;
            $display("FAIL midreset_payload_ignored: got en=%b data=%h want en=0 data=00", data_en, data_o);
        end
        checks++;
    endtask

    task automatic test_abort();
        logic       s_v[8] = '{1, 1, 0, 0, 1, 1, 0, 0};
        logic       b_v[8] = '{1, 0, 0, 0, 1, 1, 0, 0};
        logic [7:0] d_v[8] = '{8'h12, 8'h34, 8'h00, 8'h00, 8'hAB, 8'hCD, 8'h00, 8'h00};
        logic       e_v[8] = '{1, 1, 0, 0, 1, 1, 1, 0};
        logic [7:0] o_v[8] = '{8'h12, 8'h34, 8'h00, 8'h00, 8'hAB, 8'hCD, 8'h66, 8'h00};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(s_v[i], b_v[i], d_v[i]);
            if (data_en !== e_v[i] || data_o !== o_v[i]) begin
                errors++;
                $display("FAIL abort[%0d]: got en=%b data=%h want en=%b data=%h",
                         i, data_en, data_o, e_v[i], o_v[i]);
            end
            checks++;
        end
    endtask

    task automatic test_overflow();
        logic       s_v[7] = '{1, 1, 1, 1, 1, 1, 0};
        logic       b_v[7] = '{1, 0, 0, 0, 0, 1, 0};
        logic [7:0] d_v[7] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h09, 8'h00};
        logic       e_v[7] = '{1, 1, 1, 0, 0, 1, 0};
        logic [7:0] o_v[7] = '{8'h01, 8'h02, 8'h03, 8'h00, 8'h00, 8'h09, 8'h00};
        do_reset();
        for (int i = 0; i < 7; i++) begin
            drive(s_v[i], b_v[i], d_v[i]);
            if (data_en2 !== e_v[i] || data_o2 !== o_v[i]) begin
                errors++;
                $display("FAIL overflow[%0d]: got en=%b data=%h want en=%b data=%h",
                         i, data_en2, data_o2, e_v[i], o_v[i]);
            end
            checks++;
        end
    endtask

    task automatic test_back_to_back();
        logic       s_v[7] = '{1, 1, 1, 1, 1, 0, 0};
        logic       b_v[7] = '{1, 1, 1, 1, 1, 0, 0};
        logic [7:0] d_v[7] = '{8'hA5, 8'h5A, 8'h5A, 8'h5A, 8'h3C, 8'h00, 8'h00};
        logic       e_v[7] = '{1, 1, 1, 1, 1, 1, 0};
        logic [7:0] o_v[7] = '{8'hA5, 8'h5A, 8'hFF, 8'h5A, 8'h3C, 8'h66, 8'h00};
        do_reset();
        for (int i = 0; i < 7; i++) begin
            drive(s_v[i], b_v[i], d_v[i]);
            if (data_en !== e_v[i] || data_o !== o_v[i]) begin
                errors++;
                $display("FAIL back_to_back[%0d]: got en=%b data=%h want en=%b data=%h",
                         i, data_en, data_o, e_v[i], o_v[i]);
            end
            checks++;
        end
    endtask

    task automatic test_idle_noise();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 8'h77);
            if (data_en !== 1'b0 || data_o !== 8'h00) begin
                errors++;
                $display("FAIL idle_noise[%0d]: got en=%b data=%h want en=0 data=00", i, data_en, data_o);
            end
            checks++;
        end
        drive(1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        reset_n   = 1'b0;
        start     = 1'b0;
        byte_flag = 1'b0;
        data_in   = 8'h00;
        test_reset();
        test_nominal();
        test_reset_mid_frame();
        test_abort();
        test_overflow();
        test_back_to_back();
        test_idle_noise();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
